discrete_range_sequencer: RTL and testbench
===========================================

Name: discrete_range_sequencer

Overview:
Controller that drives the discrete range randomizer across every discrete variable in one solver sweep.
- On start, it reseeds the randomizer, then visits variable indices 0..NUM_DISCRETE_VARIABLES-1 in ascending order.
- For each selected index it pulses the randomizer enable, waits for the result to settle, and writes start/end/equal into the downstream range store.
- It sits between the top-level MCMC step controller and the randomizer/range-store pair.

Parameters:
NUM_DISCRETE_VARIABLES, 4, number of discrete variables visited per sweep
INDEX_WIDTH, 2, width of the variable index (log2 of NUM_DISCRETE_VARIABLES)
VALUE_WIDTH, 16, width of a range bound (matches the integer-variable width)
SETTLE_CYCLES, 1, cycles from the randomizer enable pulse until its start/end outputs are valid (≥1)

Ports:
in_clock  input  1  system clock, rising edge
in_reset  input  1  asynchronous, active-high reset
in_start  input  1  sweep request, sampled only in IDLE
in_seed  input  8  seed loaded into the randomizer at sweep start
in_variable_mask  input  NUM_DISCRETE_VARIABLES  bit i=1 means variable i is sampled; captured on start
out_busy  output  1  high from the cycle after start acceptance through DONE
out_done  output  1  one-cycle pulse at sweep end
out_rand_reset  output  1  randomizer reseed strobe
out_rand_enable  output  1  randomizer enable pulse
out_rand_seed  output  8  seed presented to the randomizer
out_variable_index  output  INDEX_WIDTH  index presented to the randomizer
in_range_start  input  VALUE_WIDTH  randomizer start bound
in_range_end  input  VALUE_WIDTH  randomizer end bound
in_range_equal  input  1  randomizer equal flag
out_write_enable  output  1  range-store write strobe
out_write_index  output  INDEX_WIDTH  range-store address
out_write_start  output  VALUE_WIDTH  registered start bound
out_write_end  output  VALUE_WIDTH  registered end bound
out_write_equal  output  1  registered equal flag
out_range_error  output  1  sticky flag, set if any captured start > end; cleared on start acceptance

Behaviour:
- Reset (asynchronous, active-high): state IDLE; every output 0; mask register 0; index 0; settle counter 0. Reset asserted mid-sweep aborts the sweep with no further write and no done pulse.
- IDLE: when in_start=1, capture in_seed and in_variable_mask, clear out_range_error, and move to SEED. in_start in any other state is ignored (not queued).
- SEED (1 cycle): out_rand_reset=1, out_rand_seed=captured seed, index=0. Next state is SELECT.
- SELECT (1 cycle per index): if mask[index]=0 and index<NUM-1, increment index and stay in SELECT. If mask[index]=0 and index=NUM-1, go to DONE. If mask[index]=1, go to ENABLE.
- ENABLE (1 cycle): out_rand_enable=1 with out_variable_index=index. Load the settle counter with SETTLE_CYCLES, then go to WAIT.
- WAIT: decrement the counter each cycle and hold out_variable_index. When the counter reaches 0 (exactly SETTLE_CYCLES cycles), go to WRITE.
- WRITE (1 cycle): out_write_enable=1; out_write_index=index; out_write_start/end/equal take the inputs registered at the WAIT→WRITE edge. If start>end (unsigned compare), set out_range_error. Then go to DONE if index=NUM-1; otherwise increment index and go to SELECT.
- DONE (1 cycle): out_done=1, out_busy=0, then go to IDLE.
- out_busy=1 in SEED, SELECT, ENABLE, WAIT and WRITE; 0 in IDLE and DONE.
- Latency: out_done is high 2 + n_sel×(3+SETTLE_CYCLES) + n_skip cycles after the accepting edge, where n_sel = selected variables and n_skip = unselected ones. With the default, full mask gives 18.
- All-zero mask: SEED, then NUM SELECT cycles, then DONE. There are no writes and no enable pulses.
- Index arithmetic never wraps, because the increment is guarded by the index=NUM-1 check.
- out_write_* data holds its last value between writes. out_rand_enable and out_write_enable are never high in the same cycle.

Decomposition:
- Shared package discrete_sequencer_pkg holds:
  - state enum: IDLE, SEED, SELECT, ENABLE, WAIT, WRITE, DONE
  - width constants: INDEX_WIDTH, VALUE_WIDTH, SEED_WIDTH=8
- Single FSM module with the settle counter inline. No sub-module is needed.

Test Plan:
1. Seed 0x5A, mask 4'b1111, SETTLE=1, start pulse → writes to indices 0, 1, 2, 3 in order, 4 cycles apart. out_done rises 18 cycles after the accepting edge. out_rand_reset is high for exactly 1 cycle with seed 0x5A.
2. Mask 4'b0101 → writes only to indices 0 and 2. out_done rises 2+2×4+2=12 cycles after start. Exactly two out_rand_enable pulses.
3. Mask 4'b0000 → zero writes and zero enables. out_done rises 6 cycles after start.
4. Model returns start=20, end=10 for index 1 → out_write_start=20, out_write_end=10, out_range_error=1 and sticky through DONE. A new start clears it.
5. Assert in_reset during WAIT of index 2 → all outputs go to 0 immediately (asynchronous). No write to index 2 and no out_done. The next start runs a full, correct sweep.
6. Pulse in_start again during busy → ignored. Exactly one out_done and an unchanged write sequence.

Source files
------------

// File: rtl/discrete_sequencer_pkg.sv
// Shared types and default widths for the discrete range sequencer.
// The sweep FSM encoding lives here so other blocks can decode it.
package discrete_sequencer_pkg;

    localparam int INDEX_WIDTH = 2;
    localparam int VALUE_WIDTH = 16;
    localparam int SEED_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        SELECT = 3'd2,
        ENABLE = 3'd3,
        WAIT   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/discrete_range_sequencer.sv
// Sweeps every selected discrete variable through the range randomizer
// and writes each settled start/end/equal result into the range store.
module discrete_range_sequencer #(
    parameter int NUM_DISCRETE_VARIABLES = 4,
    parameter int INDEX_WIDTH            = discrete_sequencer_pkg::INDEX_WIDTH,
    parameter int VALUE_WIDTH            = discrete_sequencer_pkg::VALUE_WIDTH,
    parameter int SETTLE_CYCLES          = 1
) (
    input  logic                                        in_clock,
    input  logic                                        in_reset,
    input  logic                                        in_start,
    input  logic [discrete_sequencer_pkg::SEED_WIDTH-1:0] in_seed,
    input  logic [NUM_DISCRETE_VARIABLES-1:0]           in_variable_mask,
    output logic                                        out_busy,
    output logic                                        out_done,
    output logic                                        out_rand_reset,
    output logic                                        out_rand_enable,
    output logic [discrete_sequencer_pkg::SEED_WIDTH-1:0] out_rand_seed,
    output logic [INDEX_WIDTH-1:0]                      out_variable_index,
    input  logic [VALUE_WIDTH-1:0]                      in_range_start,
    input  logic [VALUE_WIDTH-1:0]                      in_range_end,
    input  logic                                        in_range_equal,
    output logic                                        out_write_enable,
    output logic [INDEX_WIDTH-1:0]                      out_write_index,
    output logic [VALUE_WIDTH-1:0]                      out_write_start,
    output logic [VALUE_WIDTH-1:0]                      out_write_end,
    output logic                                        out_write_equal,
    output logic                                        out_range_error
);
    import discrete_sequencer_pkg::*;

    localparam int CNT_WIDTH = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_DISCRETE_VARIABLES - 1);
    localparam logic [CNT_WIDTH-1:0]   SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES);

    state_t                          state_reg, state_next;
    logic [INDEX_WIDTH-1:0]          index_reg, index_next;
    logic [CNT_WIDTH-1:0]            settle_reg, settle_next;
    logic [NUM_DISCRETE_VARIABLES-1:0] mask_reg;
    logic [SEED_WIDTH-1:0]           seed_reg;
    logic                            last_index;
    logic                            capture;

    assign last_index = (index_reg == LAST_INDEX);

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        settle_next = settle_reg;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_start) state_next = SEED;
            end
            SEED: begin
                index_next = '0;
                state_next = SELECT;
            end
            SELECT: begin
                if (mask_reg[index_reg]) begin
                    state_next = ENABLE;
                end else if (last_index) begin
                    state_next = DONE;
                end else begin
                    index_next = index_reg + 1'b1;
                end
            end
            ENABLE: begin
                settle_next = SETTLE_LOAD;
                state_next  = WAIT;
            end
            WAIT: begin
                settle_next = settle_reg - 1'b1;
                // Leaving when the count hits zero: randomizer outputs are valid now.
                if (settle_reg <= CNT_WIDTH'(1)) begin
                    settle_next = '0;
                    capture     = 1'b1;
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                if (last_index) begin
                    state_next = DONE;
                end else begin
                    index_next = index_reg + 1'b1;
                    state_next = SELECT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            settle_reg      <= '0;
            mask_reg        <= '0;
            seed_reg        <= '0;
            out_write_index <= '0;
            out_write_start <= '0;
            out_write_end   <= '0;
            out_write_equal <= 1'b0;
            out_range_error <= 1'b0;
        end else begin
            state_reg  <= state_next;
            index_reg  <= index_next;
            settle_reg <= settle_next;
            if (state_reg == IDLE && in_start) begin
                seed_reg        <= in_seed;
                mask_reg        <= in_variable_mask;
                out_range_error <= 1'b0;
            end
            if (capture) begin
                out_write_index <= index_reg;
                out_write_start <= in_range_start;
                out_write_end   <= in_range_end;
                out_write_equal <= in_range_equal;
                if (in_range_start > in_range_end) out_range_error <= 1'b1;
            end
        end
    end

    assign out_busy           = (state_reg == SEED)   || (state_reg == SELECT) ||
                                (state_reg == ENABLE) || (state_reg == WAIT)   ||
                                (state_reg == WRITE);
    assign out_done           = (state_reg == DONE);
    assign out_rand_reset     = (state_reg == SEED);
    assign out_rand_enable    = (state_reg == ENABLE);
    assign out_write_enable   = (state_reg == WRITE);
    assign out_rand_seed      = seed_reg;
    assign out_variable_index = index_reg;

endmodule

// File: tb/tb_discrete_range_sequencer.sv
// Directed bench for discrete_range_sequencer: table of sweeps plus an
// asynchronous-reset abort sequence, with a small randomizer model.
module tb_discrete_range_sequencer;

    logic        clk;
    logic        in_reset;
    logic        in_start;
    logic [7:0]  in_seed;
    logic [3:0]  in_variable_mask;
    logic        out_busy, out_done, out_rand_reset, out_rand_enable;
    logic [7:0]  out_rand_seed;
    logic [1:0]  out_variable_index;
    logic [15:0] in_range_start, in_range_end;
    logic        in_range_equal;
    logic        out_write_enable;
    logic [1:0]  out_write_index;
    logic [15:0] out_write_start, out_write_end;
    logic        out_write_equal;
    logic        out_range_error;

    discrete_range_sequencer #(
        .NUM_DISCRETE_VARIABLES(4),
        .INDEX_WIDTH(2),
        .VALUE_WIDTH(16),
        .SETTLE_CYCLES(1)
    ) dut (
        .in_clock(clk),
        .in_reset(in_reset),
        .in_start(in_start),
        .in_seed(in_seed),
        .in_variable_mask(in_variable_mask),
        .out_busy(out_busy),
        .out_done(out_done),
        .out_rand_reset(out_rand_reset),
        .out_rand_enable(out_rand_enable),
        .out_rand_seed(out_rand_seed),
        .out_variable_index(out_variable_index),
        .in_range_start(in_range_start),
        .in_range_end(in_range_end),
        .in_range_equal(in_range_equal),
        .out_write_enable(out_write_enable),
        .out_write_index(out_write_index),
        .out_write_start(out_write_start),
        .out_write_end(out_write_end),
        .out_write_equal(out_write_equal),
        .out_range_error(out_range_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Randomizer model: fixed bounds per index, index 1 optionally inverted.
    logic bad1;
    always_comb begin
        in_range_start = 16'h0100 + 16'(out_variable_index) * 16'h0011;
        in_range_end   = 16'h0800 + 16'(out_variable_index);
        in_range_equal = (out_variable_index == 2'd2);
        if (bad1 && out_variable_index == 2'd1) begin
            in_range_start = 16'd20;
            in_range_end   = 16'd10;
        end
    end

    function automatic logic [15:0] exp_start(input int i, input bit bad);
        if (bad && i == 1) return 16'd20;
        return 16'h0100 + 16'(i) * 16'h0011;
    endfunction
    function automatic logic [15:0] exp_end(input int i, input bit bad);
        if (bad && i == 1) return 16'd10;
        return 16'h0800 + 16'(i);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-sweep observations.
    int          r_lat, r_writes, r_enables, r_resets, r_dones, r_busy, r_overlap;
    logic [7:0]  r_seed_seen;
    logic        r_err_seed;
    logic [1:0]  w_idx   [8];
    logic [15:0] w_start [8];
    logic [15:0] w_end   [8];
    logic        w_equal [8];

    task automatic run_sweep(input logic [3:0] mask, input logic [7:0] seed,
                             input int restart_at, input int reset_at, input int run_cycles);
        r_lat = -1; r_writes = 0; r_enables = 0; r_resets = 0; r_dones = 0;
        r_busy = 0; r_overlap = 0; r_seed_seen = 8'h00; r_err_seed = 1'bx;
        @(negedge clk);
        in_seed = seed;
        in_variable_mask = mask;
        in_start = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_seed = ~seed;
        in_variable_mask = ~mask;
        for (int cycle = 1; cycle <= run_cycles; cycle++) begin
            @(negedge clk);
            in_start = (cycle == restart_at);
            if (cycle == reset_at + 1) in_reset = 1'b0;
            if (cycle == 1) r_err_seed = out_range_error;
            if (out_busy) r_busy++;
            if (out_rand_reset) begin
                r_resets++;
                r_seed_seen = out_rand_seed;
            end
            if (out_rand_enable) r_enables++;
            if (out_rand_enable && out_write_enable) r_overlap++;
            if (out_write_enable) begin
                if (r_writes < 8) begin
                    w_idx[r_writes]   = out_write_index;
                    w_start[r_writes] = out_write_start;
                    w_end[r_writes]   = out_write_end;
                    w_equal[r_writes] = out_write_equal;
                end
                r_writes++;
            end
            if (out_done) begin
                r_dones++;
                if (r_lat < 0) r_lat = cycle;
            end
            if (cycle == reset_at) begin
                check("abort_wait_index", 64'(out_variable_index), 64'd2);
                in_reset = 1'b1;
                #1;
                check("abort_outputs_zero",
                      64'({out_busy, out_done, out_rand_reset, out_rand_enable, out_rand_seed,
                           out_variable_index, out_write_enable, out_write_index,
                           out_write_start, out_write_end, out_write_equal, out_range_error}),
                      64'd0);
            end
        end
        in_start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] seed;
        bit         bad;
        int         restart_at;
        int         exp_lat;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check_sweep(input vec_t v, input int n);
        int k;
        int exp_n;
        exp_n = $countones(v.mask);
        check("latency",      64'(r_lat),       64'(v.exp_lat));
        check("write_count",  64'(r_writes),    64'(exp_n));
        check("enable_count", 64'(r_enables),   64'(exp_n));
        check("reseed_count", 64'(r_resets),    64'd1);
        check("reseed_value", 64'(r_seed_seen), 64'(v.seed));
        check("done_count",   64'(r_dones),     64'd1);
        check("busy_cycles",  64'(r_busy),      64'(v.exp_lat - 1));
        check("en_overlap",   64'(r_overlap),   64'd0);
        check("err_cleared",  64'(r_err_seed),  64'd0);
        check("err_sticky",   64'(out_range_error), 64'(v.exp_err));
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i] && k < r_writes && k < 8) begin
                check("write_index", 64'(w_idx[k]),   64'(i));
                check("write_start", 64'(w_start[k]), 64'(exp_start(i, v.bad)));
                check("write_end",   64'(w_end[k]),   64'(exp_end(i, v.bad)));
                check("write_equal", 64'(w_equal[k]), 64'(i == 2));
                k++;
                if (k == exp_n)
                    check("write_hold", 64'(out_write_start), 64'(exp_start(i, v.bad)));
            end
        end
        $display("sweep %0d: mask=%b seed=0x%02h writes=%0d enables=%0d done_at=%0d err=%0d",
                 n, v.mask, v.seed, r_writes, r_enables, r_lat, out_range_error);
    endtask

    initial begin
        vecs[0] = '{mask: 4'b1111, seed: 8'h5A, bad: 1'b0, restart_at: 0, exp_lat: 18, exp_err: 1'b0};
        vecs[1] = '{mask: 4'b0101, seed: 8'h3C, bad: 1'b0, restart_at: 0, exp_lat: 12, exp_err: 1'b0};
        vecs[2] = '{mask: 4'b0000, seed: 8'hA5, bad: 1'b0, restart_at: 0, exp_lat: 6,  exp_err: 1'b0};
        vecs[3] = '{mask: 4'b1111, seed: 8'h11, bad: 1'b1, restart_at: 0, exp_lat: 18, exp_err: 1'b1};
        vecs[4] = '{mask: 4'b0110, seed: 8'hC3, bad: 1'b0, restart_at: 5, exp_lat: 12, exp_err: 1'b0};

        in_reset = 1'b1;
        in_start = 1'b0;
        in_seed = 8'h00;
        in_variable_mask = 4'h0;
        bad1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({out_busy, out_done, out_rand_reset, out_rand_enable, out_rand_seed,
                   out_variable_index, out_write_enable, out_write_index,
                   out_write_start, out_write_end, out_write_equal, out_range_error}),
              64'd0);
        in_reset = 1'b0;
        $display("reset: outputs idle");

        for (int n = 0; n < 5; n++) begin
            bad1 = vecs[n].bad;
            run_sweep(vecs[n].mask, vecs[n].seed, vecs[n].restart_at, -10, 30);
            check_sweep(vecs[n], n);
        end

        // Abort during WAIT of index 2 (cycle 12 of a full-mask sweep).
        bad1 = 1'b0;
        run_sweep(4'b1111, 8'h77, 0, 12, 30);
        check("abort_writes",  64'(r_writes),  64'd2);
        check("abort_enables", 64'(r_enables), 64'd3);
        check("abort_dones",   64'(r_dones),   64'd0);
        $display("abort: writes=%0d enables=%0d dones=%0d", r_writes, r_enables, r_dones);

        run_sweep(vecs[0].mask, vecs[0].seed, 0, -10, 30);
        check_sweep(vecs[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
